// File: rtl/RF_my_pkg.sv
// Shared definitions for the register-file port sequencer: widths,
// instruction field positions, the FSM state type and the default
// write-back timeout used when RF_SEQ_TIMEOUT_EN is defined.
package RF_my_pkg;

    localparam int WD  = 32;
    localparam int SEL = 5;

    // LSB positions of the MIPS register fields inside the instruction word
    localparam int RS_LSB = 21;
    localparam int RT_LSB = 16;
    localparam int RD_LSB = 11;

    localparam logic [SEL-1:0] ZERO_REG = '0;

    localparam int DEF_TO_CYCLES = 16;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        READ    = 2'd1,
        WB_WAIT = 2'd2,
        WRITE   = 2'd3
    } seq_state_t;

    // Extract a register address field starting at the given LSB
    function automatic logic [SEL-1:0] reg_field(input logic [WD-1:0] instr, input int lsb);
        return instr[lsb +: SEL];
    endfunction

endpackage

// File: rtl/rf_port_sequencer_if.sv
// Signal bundle between the sequencer (master side) and its environment:
// instruction register / main control and the register file (slave side).
// Error_o exists only when RF_SEQ_TIMEOUT_EN is defined.
interface rf_port_sequencer_if;
    import RF_my_pkg::*;

    logic [WD-1:0]  Instr_i;
    logic           Start_i;
    logic           Ready_o;
    logic [SEL-1:0] Read_Register_1_o;
    logic [SEL-1:0] Read_Register_2_o;
    logic [WD-1:0]  Read_Data_1_i;
    logic [WD-1:0]  Read_Data_2_i;
    logic [WD-1:0]  A_o;
    logic [WD-1:0]  B_o;
    logic           Operands_Valid_o;
    logic           Wb_Valid_i;
    logic           Reg_Write_En_i;
    logic           Reg_Dst_i;
    logic           Mem_to_Reg_i;
    logic [WD-1:0]  Wb_Data_ALU_i;
    logic [WD-1:0]  Wb_Data_Mem_i;
    logic           Reg_Write_o;
    logic [SEL-1:0] Write_Register_o;
    logic [WD-1:0]  Write_Data_o;
    logic           Done_o;
`ifdef RF_SEQ_TIMEOUT_EN
    logic           Error_o;
`endif

    modport master (
        input  Instr_i, Start_i, Read_Data_1_i, Read_Data_2_i,
        input  Wb_Valid_i, Reg_Write_En_i, Reg_Dst_i, Mem_to_Reg_i,
        input  Wb_Data_ALU_i, Wb_Data_Mem_i,
        output Ready_o, Read_Register_1_o, Read_Register_2_o, A_o, B_o,
        output Operands_Valid_o, Reg_Write_o, Write_Register_o, Write_Data_o,
        output Done_o
`ifdef RF_SEQ_TIMEOUT_EN
        , output Error_o
`endif
    );

    modport slave (
        output Instr_i, Start_i, Read_Data_1_i, Read_Data_2_i,
        output Wb_Valid_i, Reg_Write_En_i, Reg_Dst_i, Mem_to_Reg_i,
        output Wb_Data_ALU_i, Wb_Data_Mem_i,
        input  Ready_o, Read_Register_1_o, Read_Register_2_o, A_o, B_o,
        input  Operands_Valid_o, Reg_Write_o, Write_Register_o, Write_Data_o,
        input  Done_o
`ifdef RF_SEQ_TIMEOUT_EN
        , input Error_o
`endif
    );

endinterface

// File: rtl/rf_seq_timer.sv
// Write-back timeout counter for the register-file sequencer.
// Compiled only when RF_SEQ_TIMEOUT_EN is defined. The count clears while
// the sequencer is in READ (i.e. on entry to WB_WAIT), advances on every
// WB_WAIT cycle without write-back data, and flags hit once it equals
// TO_CYCLES.
`ifdef RF_SEQ_TIMEOUT_EN
module rf_seq_timer
    import RF_my_pkg::*;
#(
    parameter int TO_CYCLES = DEF_TO_CYCLES
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic inc,
    output logic hit
);

    localparam int CW = $clog2(TO_CYCLES + 1);

    logic [CW-1:0] count_reg;

    assign hit = (count_reg == CW'(TO_CYCLES));

    // Waiting-cycle counter; holds at the limit so it never wraps
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_reg <= '0;
        end else if (clr) begin
            count_reg <= '0;
        end else if (inc && !hit) begin
            count_reg <= count_reg + CW'(1);
        end
    end

endmodule
`endif

// File: rtl/rf_port_sequencer.sv
// Register-file access sequencer for the multicycle MIPS datapath.
// Captures an instruction, reads rs/rt into A/B, waits for write-back data
// and issues one write strobe (suppressed for $zero).
// Optional feature macro: RF_SEQ_TIMEOUT_EN adds a write-back timeout
// (rf_seq_timer) with an Error_o pulse; without it WB_WAIT waits forever.
module rf_port_sequencer
    import RF_my_pkg::*;
`ifdef RF_SEQ_TIMEOUT_EN
#(
    parameter int TO_CYCLES = DEF_TO_CYCLES
)
`endif
(
    input  logic                clk,
    input  logic                reset,
    rf_port_sequencer_if.master bus
);

    seq_state_t     state_reg;
    seq_state_t     state_next;

    logic [WD-1:0]  ir_reg;
    logic [WD-1:0]  a_reg;
    logic [WD-1:0]  b_reg;
    logic [SEL-1:0] wr_addr_reg;
    logic [WD-1:0]  wr_data_reg;

    logic           ready;
    logic           operands_valid;
    logic           reg_write;
    logic           done;
    logic           error;
    logic           timeout_hit;

    logic [SEL-1:0] rs_addr;
    logic [SEL-1:0] rt_addr;
    logic [SEL-1:0] rd_addr;
    logic [SEL-1:0] dst_addr;
    logic [WD-1:0]  wb_data;
    logic           wb_accept;

    // Opcode/funct bits are carried in the IR but not needed here
    logic           unused_ir_bits;
    assign unused_ir_bits = ^{ir_reg[31:26], ir_reg[10:0]};

    assign rs_addr   = reg_field(ir_reg, RS_LSB);
    assign rt_addr   = reg_field(ir_reg, RT_LSB);
    assign rd_addr   = reg_field(ir_reg, RD_LSB);
    assign dst_addr  = bus.Reg_Dst_i ? rd_addr : rt_addr;
    assign wb_data   = bus.Mem_to_Reg_i ? bus.Wb_Data_Mem_i : bus.Wb_Data_ALU_i;
    assign wb_accept = (state_reg == WB_WAIT) && bus.Wb_Valid_i && bus.Reg_Write_En_i;

`ifdef RF_SEQ_TIMEOUT_EN
    rf_seq_timer #(
        .TO_CYCLES (TO_CYCLES)
    ) u_timer (
        .clk   (clk),
        .reset (reset),
        .clr   (state_reg == READ),
        .inc   ((state_reg == WB_WAIT) && !bus.Wb_Valid_i),
        .hit   (timeout_hit)
    );
    assign bus.Error_o = error;
`else
    assign timeout_hit = 1'b0;
`endif

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state and per-state strobes; write-back data beats the timeout
    always_comb begin
        state_next     = state_reg;
        ready          = 1'b0;
        operands_valid = 1'b0;
        reg_write      = 1'b0;
        done           = 1'b0;
        error          = 1'b0;
        case (state_reg)
            IDLE: begin
                ready = 1'b1;
                if (bus.Start_i) begin
                    state_next = READ;
                end
            end
            READ: begin
                state_next = WB_WAIT;
            end
            WB_WAIT: begin
                operands_valid = 1'b1;
                if (bus.Wb_Valid_i) begin
                    if (bus.Reg_Write_En_i) begin
                        state_next = WRITE;
                    end else begin
                        done       = 1'b1;
                        state_next = IDLE;
                    end
                end else if (timeout_hit) begin
                    error      = 1'b1;
                    state_next = IDLE;
                end
            end
            WRITE: begin
                reg_write  = (wr_addr_reg != ZERO_REG);
                done       = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Datapath registers: IR capture, operand latch, write-back capture
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ir_reg      <= '0;
            a_reg       <= '0;
            b_reg       <= '0;
            wr_addr_reg <= '0;
            wr_data_reg <= '0;
        end else begin
            if ((state_reg == IDLE) && bus.Start_i) begin
                ir_reg <= bus.Instr_i;
            end
            if (state_reg == READ) begin
                a_reg <= bus.Read_Data_1_i;
                b_reg <= bus.Read_Data_2_i;
            end
            if (wb_accept) begin
                wr_addr_reg <= dst_addr;
                wr_data_reg <= wb_data;
            end
        end
    end

    assign bus.Ready_o           = ready;
    assign bus.Read_Register_1_o = rs_addr;
    assign bus.Read_Register_2_o = rt_addr;
    assign bus.A_o               = a_reg;
    assign bus.B_o               = b_reg;
    assign bus.Operands_Valid_o  = operands_valid;
    assign bus.Reg_Write_o       = reg_write;
    assign bus.Write_Register_o  = wr_addr_reg;
    assign bus.Write_Data_o      = wr_data_reg;
    assign bus.Done_o            = done;

endmodule

// File: doc/rf_port_sequencer.md
# rf_port_sequencer

Register-file access sequencer for the multicycle MIPS datapath; it is the initiator side of the register-file port set. It takes an instruction word from the instruction register, drives the two read addresses, latches operands A/B, then waits for the write-back value and issues a single write strobe to the register file. It sits between the instruction register / main control and the register file, replacing ad-hoc A/B registers and write-back muxing.

## Interface
- WD, 32, data width (from RF_my_pkg)
- SEL, 5, register address width (from RF_my_pkg)
- TO_CYCLES, 16, write-back timeout limit; used only with RF_SEQ_TIMEOUT_EN
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high
- Instr_i  in  WD  instruction word; rs=[25:21], rt=[20:16], rd=[15:11]
- Start_i  in  1  begin sequence; sampled only in IDLE
- Ready_o  out  1  high in IDLE
- Read_Register_1_o / Read_Register_2_o  out  SEL  rs / rt of the captured instruction
- Read_Data_1_i / Read_Data_2_i  in  WD  combinational read data from the RF
- A_o / B_o  out  WD  latched operands
- Operands_Valid_o  out  1  high throughout WB_WAIT
- Wb_Valid_i  in  1  write-back data present this cycle
- Reg_Write_En_i  in  1  instruction writes a register; qualified by Wb_Valid_i
- Reg_Dst_i  in  1  0: destination rt, 1: destination rd
- Mem_to_Reg_i  in  1  0: Wb_Data_ALU_i, 1: Wb_Data_Mem_i
- Wb_Data_ALU_i / Wb_Data_Mem_i  in  WD  write-back sources
- Reg_Write_o  out  1  write strobe to the RF
- Write_Register_o  out  SEL  write address
- Write_Data_o  out  WD  write data
- Done_o  out  1  one-cycle completion pulse
- Error_o  out  1  one-cycle timeout pulse; present only with RF_SEQ_TIMEOUT_EN

## Operation
- States: IDLE, READ, WB_WAIT, WRITE.
- IDLE: Ready_o=1. If Start_i=1, capture Instr_i into the internal IR and go to READ. Start_i is ignored in every other state.
- READ: addresses driven from the captured rs/rt. At the clock edge, A_o<=Read_Data_1_i and B_o<=Read_Data_2_i, then go to WB_WAIT.
- WB_WAIT: Operands_Valid_o=1.
  - Wb_Valid_i=1 and Reg_Write_En_i=1: register the destination (rd if Reg_Dst_i=1, else rt) and the data (Mem_to_Reg_i select), then go to WRITE.
  - Wb_Valid_i=1 and Reg_Write_En_i=0: pulse Done_o and go to IDLE.
- WRITE: Reg_Write_o=1 for exactly one cycle, with Write_Register_o/Write_Data_o held from registers. Done_o pulses in the same cycle, then go to IDLE.
- Destination 0 ($zero): in WRITE, Reg_Write_o stays 0; Done_o still pulses.
- Read addresses stay stable from READ through WRITE; they hold the last values in IDLE.
- Reset at any time: state forced to IDLE, any in-flight write is dropped, no strobe is issued.
- Reset values: Ready_o=1, all other outputs 0; A/B/IR/write registers 0.

## Timing
- Start_i sampled at edge 0 → READ in cycle 1 → A_o/B_o valid from cycle 2, with Operands_Valid_o=1 from cycle 2.
- Wb_Valid_i sampled at edge n → Reg_Write_o high in cycle n+1 → RF updated at edge n+2.
- Minimum Start-to-Done: 3 cycles. Ready_o returns the cycle after Done_o.
- Wb_Valid_i in the first WB_WAIT cycle is legal.

## Configuration
- RF_SEQ_TIMEOUT_EN defined:
  - A counter of width $clog2(TO_CYCLES+1) clears on entry to WB_WAIT and increments each WB_WAIT cycle without Wb_Valid_i.
  - On reaching TO_CYCLES: pulse Error_o, go to IDLE, no write.
  - Wb_Valid_i in the same cycle as the limit wins (normal path).
- RF_SEQ_TIMEOUT_EN undefined: no counter, no Error_o port, WB_WAIT waits indefinitely.

## Structure
- RF_my_pkg: WD, SEL, state enum typedef (IDLE/READ/WB_WAIT/WRITE), instruction field bit positions, ZERO_REG=0, default TO_CYCLES.
- Sub-module rf_seq_timer: the timeout counter, instantiated only under RF_SEQ_TIMEOUT_EN.
- Bench instantiates rf_port_sequencer connected to RF_TOP.

## Test plan
- Reset, preload RF reg9=5 and reg10=7, Instr_i=0x012A4020, Start_i pulse → Read_Register_1_o=9, Read_Register_2_o=10; cycle 2: A_o=5, B_o=7, Operands_Valid_o=1.
- Same instruction with Wb_Valid_i=1, Reg_Dst_i=1, Mem_to_Reg_i=0, Wb_Data_ALU_i=12 → next cycle Reg_Write_o=1, Write_Register_o=8, Write_Data_o=12, Done_o=1; RF reg8 reads 12.
- Reg_Dst_i=0, Mem_to_Reg_i=1, Wb_Data_Mem_i=0xDEADBEEF → write to reg10=0xDEADBEEF.
- Instruction with rd=0, Reg_Dst_i=1 → Reg_Write_o stays 0, Done_o=1, RF reg0 stays 0.
- Start_i held high during WB_WAIT, then reset asserted mid-WB_WAIT → no second capture; after reset: IDLE, Ready_o=1, Reg_Write_o=0, A_o=B_o=0.
- With RF_SEQ_TIMEOUT_EN and TO_CYCLES=4, Wb_Valid_i never asserted → Error_o pulses after 4 WB_WAIT cycles, Ready_o=1 next cycle, no write.
